// File: rtl/bridge_pkg.sv
// Shared frame constants, FSM state encoding and helpers for the request bridge.
// Optional feature: FRAME_CHECKSUM_EN adds the CSUM state (trailing XOR byte).
package bridge_pkg;

  localparam logic [7:0] HDR_WR = 8'h57;
  localparam logic [7:0] HDR_RD = 8'h52;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3
`ifdef FRAME_CHECKSUM_EN
    ,
    CSUM = 3'd4
`endif
  } frame_state_e;

  // Header byte for a request direction.
  function automatic logic [7:0] hdr_byte(input logic is_wr);
    return is_wr ? HDR_WR : HDR_RD;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Request FIFO: synchronous push/pop, full/empty/level evaluated on registered state.
// Ports: clk, reset (async, active-high), push/wdata, pop/rdata (head, show-ahead),
//        full, empty, level (occupied entries), drop (pulse after a rejected push).
module req_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok_c;
  logic          pop_ok_c;
  logic [LW-1:0] level_nxt_c;

  // Full/empty come from registers, so a push on a full FIFO loses even if a pop happens too.
  assign push_ok_c   = push && !full;
  assign pop_ok_c    = pop && !empty;
  assign level_nxt_c = level + LW'(push_ok_c) - LW'(pop_ok_c);
  assign rdata       = mem[rptr];

  // Pointers, occupancy flags and drop pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      drop  <= 1'b0;
    end else begin
      if (push_ok_c) wptr <= wptr + AW'(1);
      if (pop_ok_c)  rptr <= rptr + AW'(1);
      level <= level_nxt_c;
      full  <= (level_nxt_c == LW'(DEPTH));
      empty <= (level_nxt_c == LW'(0));
      drop  <= push && full;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/req_frame_tx.sv
// Queues APB requests and serialises each as a byte frame toward a UART transmitter:
//   header (0x57 write / 0x52 read), address bytes MSB first, data bytes MSB first (writes
//   only) and, with FRAME_CHECKSUM_EN defined, an XOR checksum of all preceding bytes.
// Ports: apb_clk, reset (async, active-high); wrreq/wr/wenfifo push side with
//        wait_fifo/fifo_level/drop status; tx_data/tx_valid/tx_ready byte stream; busy.
module req_frame_tx
  import bridge_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDRBITS = 16,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                        apb_clk,
  input  logic                        reset,
  input  logic [WIDTH+ADDRBITS-1:0]   wrreq,
  input  logic                        wr,
  input  logic                        wenfifo,
  output logic                        wait_fifo,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        drop,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy
);

  localparam int unsigned ENT_W     = 1 + WIDTH + ADDRBITS;
  localparam int unsigned A_BYTES   = ADDRBITS / 8;
  localparam int unsigned D_BYTES   = WIDTH / 8;
  localparam int unsigned MAX_BYTES = (A_BYTES > D_BYTES) ? A_BYTES : D_BYTES;
  localparam int unsigned CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_BYTES - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(D_BYTES - 1);

  frame_state_e        state;
  logic [ENT_W-1:0]    head;
  logic                fifo_empty;
  logic                pop_c;
  logic                accept_c;
  logic                is_wr;
  logic [ADDRBITS-1:0] addr_sh;
  logic [WIDTH-1:0]    data_sh;
  logic [CNT_W-1:0]    byte_cnt;

  assign pop_c    = (state == IDLE) && !fifo_empty;
  assign accept_c = tx_valid && tx_ready;

  req_fifo #(
    .DW    (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (apb_clk),
    .reset (reset),
    .push  (wenfifo),
    .wdata ({wr, wrreq}),
    .pop   (pop_c),
    .rdata (head),
    .full  (wait_fifo),
    .empty (fifo_empty),
    .level (fifo_level),
    .drop  (drop)
  );

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of every accepted byte of the current frame.
  always_ff @(posedge apb_clk or posedge reset) begin
    if (reset)                         csum <= '0;
    else if (pop_c)                    csum <= '0;
    else if (accept_c && state != CSUM) csum <= csum ^ tx_data;
  end
`endif

  // Frame sequencer: the next byte is loaded on the edge that accepts the current one.
  always_ff @(posedge apb_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      is_wr    <= 1'b0;
      addr_sh  <= '0;
      data_sh  <= '0;
      byte_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            is_wr    <= head[ENT_W-1];
            addr_sh  <= head[WIDTH+ADDRBITS-1:WIDTH];
            data_sh  <= head[WIDTH-1:0];
            tx_data  <= hdr_byte(head[ENT_W-1]);
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (accept_c) begin
            tx_data  <= addr_sh[ADDRBITS-1 -: 8];
            addr_sh  <= addr_sh << 8;
            byte_cnt <= '0;
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (accept_c) begin
            if (byte_cnt != A_LAST) begin
              tx_data  <= addr_sh[ADDRBITS-1 -: 8];
              addr_sh  <= addr_sh << 8;
              byte_cnt <= byte_cnt + CNT_W'(1);
            end else if (is_wr) begin
              tx_data  <= data_sh[WIDTH-1 -: 8];
              data_sh  <= data_sh << 8;
              byte_cnt <= '0;
              state    <= DATA;
            end else begin
`ifdef FRAME_CHECKSUM_EN
              tx_data <= csum ^ tx_data;
              state   <= CSUM;
`else
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
`endif
            end
          end
        end
        DATA: begin
          if (accept_c) begin
            if (byte_cnt != D_LAST) begin
              tx_data  <= data_sh[WIDTH-1 -: 8];
              data_sh  <= data_sh << 8;
              byte_cnt <= byte_cnt + CNT_W'(1);
            end else begin
`ifdef FRAME_CHECKSUM_EN
              tx_data <= csum ^ tx_data;
              state   <= CSUM;
`else
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
`endif
            end
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CSUM: begin
          if (accept_c) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
`endif
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_frame_tx.sv
// Self-checking bench for req_frame_tx with default parameters (WIDTH=32, ADDRBITS=16, DEPTH=8).
// Expected byte streams come from a frame model built from the frame format rules.
module tb_req_frame_tx;

  localparam int unsigned W = 32;
  localparam int unsigned A = 16;
  localparam int unsigned D = 8;

  logic           apb_clk = 1'b0;
  logic           reset   = 1'b1;
  logic [A+W-1:0] wrreq   = '0;
  logic           wr      = 1'b0;
  logic           wenfifo = 1'b0;
  logic           wait_fifo;
  logic [3:0]     fifo_level;
  logic           drop;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready = 1'b0;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  req_frame_tx #(.WIDTH(W), .ADDRBITS(A), .DEPTH(D)) dut (
    .apb_clk    (apb_clk),
    .reset      (reset),
    .wrreq      (wrreq),
    .wr         (wr),
    .wenfifo    (wenfifo),
    .wait_fifo  (wait_fifo),
    .fifo_level (fifo_level),
    .drop       (drop),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy)
  );

  always #5 apb_clk = ~apb_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame model: header, address MSB first, data MSB first for writes, optional XOR byte.
  task automatic model_push(input logic w, input logic [A+W-1:0] req);
    logic [7:0] b;
    logic [7:0] cs;
    b = w ? 8'h57 : 8'h52;
    cs = b;
    exp_q.push_back(b);
    for (int i = A/8 - 1; i >= 0; i--) begin
      b = req[W + i*8 +: 8];
      cs = cs ^ b;
      exp_q.push_back(b);
    end
    if (w) begin
      for (int i = W/8 - 1; i >= 0; i--) begin
        b = req[i*8 +: 8];
        cs = cs ^ b;
        exp_q.push_back(b);
      end
    end
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic cyc();
    @(posedge apb_clk);
    #1;
  endtask

  // One push cycle; the model is told only about pushes that must be accepted.
  task automatic push_step(input logic w, input logic [A+W-1:0] req, input logic accept);
    wr = w;
    wrreq = req;
    wenfifo = 1'b1;
    if (accept) model_push(w, req);
    cyc();
    wenfifo = 1'b0;
  endtask

  task automatic drain(input int limit);
    tx_ready = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    cyc();
    cyc();
    chk("drain_idle_busy", 64'(busy), 64'd0);
    chk("drain_idle_valid", 64'(tx_valid), 64'd0);
  endtask

  function automatic logic [A+W-1:0] rnd_req();
    return {16'($urandom), 32'($urandom)};
  endfunction

  // Byte monitor at the falling edge: scoreboard accepted bytes, check hold while stalled.
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = '0;
  always @(negedge apb_clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 64'(tx_valid), 64'd1);
        chk("hold_data", 64'(tx_data), 64'(pd));
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        if (exp_q.size() == 0) chk("byte_expected_avail", 64'(exp_q.size()), 64'd1);
        else chk("byte", 64'(tx_data), 64'(exp_q.pop_front()));
      end
      pv = tx_valid;
      pr = tx_ready;
      pd = tx_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e36 [7];
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] e37 [4];
`else
    logic [7:0] e37 [3];
`endif
    logic [A+W-1:0] r;
    logic           w;
    e36 = '{8'h57, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef FRAME_CHECKSUM_EN
    e37 = '{8'h52, 8'hFF, 8'hE0, 8'h4D};
`else
    e37 = '{8'h52, 8'hFF, 8'hE0};
`endif

    // Reset values
    cyc();
    cyc();
    chk("rst_wait_fifo", 64'(wait_fifo), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    cyc();

    // Write frame and first-byte latency
    tx_ready = 1'b1;
    got_q.delete();
    push_step(1'b1, 48'h1234_DEADBEEF, 1'b1);
    chk("lat_cycle1_valid", 64'(tx_valid), 64'd0);
    cyc();
    chk("lat_cycle2_valid", 64'(tx_valid), 64'd1);
    chk("lat_cycle2_data", 64'(tx_data), 64'h57);
    chk("lat_cycle2_busy", 64'(busy), 64'd1);
    drain(50);
    chk("wr_frame_len", 64'(got_q.size()), 64'(7));
    for (int i = 0; i < 7; i++) chk("wr_frame_byte", 64'(got_q[i]), 64'(e36[i]));

    // Read frame
    got_q.delete();
    push_step(1'b0, 48'hFFE0_00000000, 1'b1);
    drain(50);
    chk("rd_frame_len", 64'(got_q.size()), 64'($size(e37)));
    for (int i = 0; i < $size(e37); i++) chk("rd_frame_byte", 64'(got_q[i]), 64'(e37[i]));

    // Overflow: frame stalled in flight, then 9 back-to-back pushes
    tx_ready = 1'b0;
    push_step(1'b1, rnd_req(), 1'b1);
    cyc();
    chk("ovf_prime_busy", 64'(busy), 64'd1);
    chk("ovf_prime_level", 64'(fifo_level), 64'd0);
    for (int i = 0; i < 8; i++) push_step(1'($urandom), rnd_req(), 1'b1);
    chk("ovf_full_after8", 64'(wait_fifo), 64'd1);
    chk("ovf_level_after8", 64'(fifo_level), 64'd8);
    chk("ovf_no_drop_yet", 64'(drop), 64'd0);
    push_step(1'b1, rnd_req(), 1'b0);
    chk("ovf_drop_pulse", 64'(drop), 64'd1);
    chk("ovf_level_after9", 64'(fifo_level), 64'd8);
    cyc();
    chk("ovf_drop_single", 64'(drop), 64'd0);
    drain(400);
    chk("ovf_level_drained", 64'(fifo_level), 64'd0);
    chk("ovf_not_full", 64'(wait_fifo), 64'd0);

    // tx_ready toggling every cycle
    push_step(1'b1, rnd_req(), 1'b1);
    push_step(1'b0, rnd_req(), 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      tx_ready = ~tx_ready;
      cyc();
    end
    drain(50);

    // Simultaneous push and pop at level 3
    tx_ready = 1'b0;
    push_step(1'b1, rnd_req(), 1'b1);
    cyc();
    for (int i = 0; i < 3; i++) push_step(1'($urandom), rnd_req(), 1'b1);
    chk("pp_level_before", 64'(fifo_level), 64'd3);
    tx_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (!busy) break;
    end
    chk("pp_idle_reached", 64'(busy), 64'd0);
    chk("pp_level_idle", 64'(fifo_level), 64'd3);
    push_step(1'b0, rnd_req(), 1'b1);
    chk("pp_level_after", 64'(fifo_level), 64'd3);
    chk("pp_busy_after", 64'(busy), 64'd1);
    drain(200);

    // Reset after the third byte of a write
    tx_ready = 1'b1;
    got_q.delete();
    push_step(1'b1, rnd_req(), 1'b1);
    push_step(1'b1, rnd_req(), 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (got_q.size() >= 3) break;
      cyc();
    end
    chk("mid_third_byte_seen", 64'(got_q.size()), 64'd3);
    chk("mid_level_before", 64'(fifo_level), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 64'(tx_valid), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_data", 64'(tx_data), 64'd0);
    cyc();
    cyc();
    reset = 1'b0;
    got_q.delete();
    cyc();
    chk("mid_no_resume", 64'(tx_valid), 64'd0);
    r = rnd_req();
    push_step(1'b0, r, 1'b1);
    drain(50);
    chk("mid_fresh_len", 64'(got_q.size()), 64'($size(e37)));
    chk("mid_fresh_hdr", 64'(got_q[0]), 64'h52);

    // Randomized traffic against the frame model
    for (int i = 0; i < 400; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if (($urandom_range(0, 2) == 0) && !wait_fifo) begin
        w = 1'($urandom);
        r = rnd_req();
        push_step(w, r, 1'b1);
      end else begin
        cyc();
      end
    end
    drain(2000);
    chk("final_level", 64'(fifo_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
